// File: rtl/fir_link_host.sv
// fir_link_host -- host-side link controller for a UART-attached FIR filter.
//
// Samples are queued in a small FIFO, popped one at a time and sent to a
// byte-wide UART transmitter as an LSB/MSB pair. Bytes returned by the UART
// receiver are paired back into 16-bit results. If the MSB of a pair does not
// arrive in time, the half-received pair is dropped so that the receive path
// cannot stay out of step.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   sample_in/valid/ready sample stream into the FIFO (valid/ready handshake)
//   TxD_start/TxD_data    one-cycle send request and byte to the UART
//   TxD_busy              UART transmitter busy
//   RxD_data_ready/RxD_data  received byte strobe and byte
//   result_out/valid      reassembled {MSB,LSB} result and its update pulse
//   rx_error              pulse when a received pair times out
//   outstanding           samples sent minus results received (saturating)
module fir_link_host #(
  parameter int FIFO_DEPTH        = 8,
  parameter int RX_TIMEOUT        = 1000000,
  parameter int OUTSTANDING_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         TxD_start,
  output logic [7:0]                   TxD_data,
  input  logic                         TxD_busy,
  input  logic                         RxD_data_ready,
  input  logic [7:0]                   RxD_data,
  output logic [15:0]                  result_out,
  output logic                         result_valid,
  output logic                         rx_error,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  localparam logic [2:0] TX_IDLE = 3'd0;
  localparam logic [2:0] TX_LSB  = 3'd1;
  localparam logic [2:0] TX_GAP1 = 3'd2;
  localparam logic [2:0] TX_MSB  = 3'd3;
  localparam logic [2:0] TX_GAP2 = 3'd4;

  localparam logic [0:0] RX_LSB = 1'b0;
  localparam logic [0:0] RX_MSB = 1'b1;

  // ---------------- sample FIFO ----------------
  logic [FIFO_DEPTH-1:0][15:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [2:0]                  tx_state;
  logic                        push, pop;

  assign sample_ready = (count != CW'(FIFO_DEPTH));
  assign push         = sample_valid && sample_ready;
  assign pop          = (tx_state == TX_IDLE) && (count != '0);

  // Storage needs no reset: count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  logic [15:0] word_reg;
  logic        msb_start;

  assign msb_start = (tx_state == TX_MSB) && !TxD_busy;

  // The GAP states give the UART one cycle to raise TxD_busy after a start,
  // so a stale low busy is never mistaken for "ready for the next byte".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state  <= TX_IDLE;
      word_reg  <= '0;
      TxD_start <= 1'b0;
      TxD_data  <= '0;
    end else begin
      TxD_start <= 1'b0;
      case (tx_state)
        TX_IDLE: if (count != '0) begin
          word_reg <= mem[rd_ptr];
          tx_state <= TX_LSB;
        end
        TX_LSB: if (!TxD_busy) begin
          TxD_start <= 1'b1;
          TxD_data  <= word_reg[7:0];
          tx_state  <= TX_GAP1;
        end
        TX_GAP1: tx_state <= TX_MSB;
        TX_MSB: if (!TxD_busy) begin
          TxD_start <= 1'b1;
          TxD_data  <= word_reg[15:8];
          tx_state  <= TX_GAP2;
        end
        TX_GAP2: tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive FSM ----------------
  logic [0:0]    rx_state;
  logic [7:0]    lsb_reg;
  logic [TW-1:0] timer;
  logic          rx_done;

  assign rx_done = (rx_state == RX_MSB) && RxD_data_ready;

  // A strobe in the expiry cycle wins over the timeout: it completes the pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state     <= RX_LSB;
      lsb_reg      <= '0;
      timer        <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      rx_error     <= 1'b0;
      if (rx_state == RX_LSB) begin
        if (RxD_data_ready) begin
          lsb_reg  <= RxD_data;
          timer    <= '0;
          rx_state <= RX_MSB;
        end
      end else begin
        if (RxD_data_ready) begin
          result_out   <= {RxD_data, lsb_reg};
          result_valid <= 1'b1;
          rx_state     <= RX_LSB;
        end else if (timer == TW'(RX_TIMEOUT - 1)) begin
          rx_error <= 1'b1;
          lsb_reg  <= '0;
          rx_state <= RX_LSB;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  // ---------------- in-flight counter ----------------
  // Moves on the same edge that registers the MSB start / result pulse,
  // so it is in step with TxD_start and result_valid as seen outside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else if (msb_start && !rx_done) begin
      if (outstanding != '1) outstanding <= outstanding + 1'b1;
    end else if (rx_done && !msb_start) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_link_host.sv
// Directed testbench for fir_link_host with a simple UART model: every
// TxD_start makes TxD_busy high for the following 10 cycles; 'stuck' holds
// busy high indefinitely.
module tb_fir_link_host;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        TxD_busy;
  logic        RxD_data_ready = 1'b0;
  logic [7:0]  RxD_data = '0;
  logic [15:0] result_out;
  logic        result_valid;
  logic        rx_error;
  logic [7:0]  outstanding;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  logic stuck = 1'b0;
  logic [7:0] txq[$];

  fir_link_host #(.FIFO_DEPTH(8), .RX_TIMEOUT(100), .OUTSTANDING_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .TxD_start(TxD_start), .TxD_data(TxD_data), .TxD_busy(TxD_busy),
    .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
    .result_out(result_out), .result_valid(result_valid), .rx_error(rx_error),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  assign TxD_busy = stuck || (busy_cnt != 0);

  always @(posedge clk) begin
    if (TxD_start) begin
      busy_cnt <= 10;
      txq.push_back(TxD_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    RxD_data = b;
    RxD_data_ready = 1'b1;
    step();
    RxD_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({TxD_start, TxD_data, result_out, result_valid, rx_error, outstanding, sample_ready}
        !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_in got start=%b data=%h res=%h rv=%b err=%b out=%0d rdy=%b exp zeros rdy=1",
               TxD_start, TxD_data, result_out, result_valid, rx_error, outstanding, sample_ready);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({TxD_start, sample_ready, outstanding} !== {1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL reset_after got start=%b rdy=%b out=%0d exp 0 1 0", TxD_start, sample_ready, outstanding);
    end
  endtask

  task automatic test_single();
    int n;
    sample_in = 16'hA55A;
    sample_valid = 1'b1;
    step();                       // cycle 1
    sample_valid = 1'b0;
    step();                       // cycle 2
    checks++;
    if (TxD_start !== 1'b0) begin failures++; $display("FAIL single_c2 got start=%b exp 0", TxD_start); end
    step();                       // cycle 3
    checks++;
    if ({TxD_start, TxD_data, outstanding} !== {1'b1, 8'h5A, 8'd0}) begin
      failures++;
      $display("FAIL single_lsb got start=%b data=%h out=%0d exp 1 5a 0", TxD_start, TxD_data, outstanding);
    end
    step();                       // cycle 4
    checks++;
    if ({TxD_start, TxD_data, TxD_busy} !== {1'b0, 8'h5A, 1'b1}) begin
      failures++;
      $display("FAIL single_hold got start=%b data=%h busy=%b exp 0 5a 1", TxD_start, TxD_data, TxD_busy);
    end
    n = 4;
    while (!TxD_start && n < 60) begin step(); n++; end
    checks++;
    if ({n, TxD_data, outstanding} !== {32'd15, 8'hA5, 8'd1}) begin
      failures++;
      $display("FAIL single_msb got cycle=%0d data=%h out=%0d exp 15 a5 1", n, TxD_data, outstanding);
    end
  endtask

  task automatic test_result();
    rx_byte(8'h34);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL res_lsb got rv=%b exp 0", result_valid); end
    repeat (49) step();
    rx_byte(8'h12);
    checks++;
    if ({result_valid, result_out, outstanding} !== {1'b1, 16'h1234, 8'd0}) begin
      failures++;
      $display("FAIL res_msb got rv=%b res=%h out=%0d exp 1 1234 0", result_valid, result_out, outstanding);
    end
    step();
    checks++;
    if ({result_valid, result_out} !== {1'b0, 16'h1234}) begin
      failures++;
      $display("FAIL res_pulse got rv=%b res=%h exp 0 1234", result_valid, result_out);
    end
  endtask

  task automatic test_timeout();
    rx_byte(8'h77);
    repeat (99) step();
    checks++;
    if (rx_error !== 1'b0) begin failures++; $display("FAIL tmo_early got err=%b exp 0", rx_error); end
    step();
    checks++;
    if ({rx_error, result_valid, result_out} !== {1'b1, 1'b0, 16'h1234}) begin
      failures++;
      $display("FAIL tmo_fire got err=%b rv=%b res=%h exp 1 0 1234", rx_error, result_valid, result_out);
    end
    step();
    checks++;
    if (rx_error !== 1'b0) begin failures++; $display("FAIL tmo_pulse got err=%b exp 0", rx_error); end
    rx_byte(8'hCD);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL tmo_lsb got rv=%b exp 0", result_valid); end
    rx_byte(8'hAB);
    checks++;
    if ({result_valid, result_out, outstanding, rx_error} !== {1'b1, 16'hABCD, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL tmo_resync got rv=%b res=%h out=%0d err=%b exp 1 abcd 0 0",
               result_valid, result_out, outstanding, rx_error);
    end
  endtask

  task automatic test_priority();
    rx_byte(8'h11);
    repeat (99) step();
    rx_byte(8'h22);               // strobe lands on the expiry cycle
    checks++;
    if ({result_valid, rx_error, result_out} !== {1'b1, 1'b0, 16'h2211}) begin
      failures++;
      $display("FAIL prio got rv=%b err=%b res=%h exp 1 0 2211", result_valid, rx_error, result_out);
    end
    step();
    checks++;
    if (rx_error !== 1'b0) begin failures++; $display("FAIL prio_after got err=%b exp 0", rx_error); end
  endtask

  task automatic test_reset_mid();
    int n;
    int starts;
    n = 0;
    while (TxD_busy && n < 100) begin step(); n++; end
    stuck = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample_in = 16'(i * 16'h0101);
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    step();
    stuck = 1'b0;
    step();                       // LSB start cycle, FSM now in TX_GAP1, 3 queued
    checks++;
    if ({TxD_start, TxD_data} !== {1'b1, 8'h01}) begin
      failures++;
      $display("FAIL mid_pre got start=%b data=%h exp 1 01", TxD_start, TxD_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({TxD_start, TxD_data, result_out, result_valid, rx_error, outstanding, sample_ready}
        !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL mid_async got start=%b data=%h res=%h rv=%b err=%b out=%0d rdy=%b exp zeros rdy=1",
               TxD_start, TxD_data, result_out, result_valid, rx_error, outstanding, sample_ready);
    end
    step();
    step();
    reset = 1'b1;
    starts = 0;
    for (int i = 0; i < 40; i++) begin step(); if (TxD_start) starts++; end
    checks++;
    if (starts !== 0) begin failures++; $display("FAIL mid_quiet got starts=%0d exp 0", starts); end
    sample_in = 16'hBEEF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    checks++;
    if ({TxD_start, TxD_data} !== {1'b1, 8'hEF}) begin
      failures++;
      $display("FAIL mid_new got start=%b data=%h exp 1 ef", TxD_start, TxD_data);
    end
  endtask

  task automatic test_fifo_full();
    int v;
    int acc;
    int n;
    logic fire;
    do_reset();
    n = 0;
    while (TxD_busy && n < 100) begin step(); n++; end
    stuck = 1'b1;
    v = 1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      sample_in = 16'(v);
      sample_valid = (v <= 10);
      fire = sample_valid && sample_ready;
      step();
      if (fire) begin v++; acc++; end
    end
    checks++;
    if ({acc, sample_ready, sample_in} !== {32'd9, 1'b0, 16'h000A}) begin
      failures++;
      $display("FAIL full_stall got acc=%0d rdy=%b in=%h exp 9 0 000a", acc, sample_ready, sample_in);
    end
    txq.delete();
    stuck = 1'b0;
    n = 0;
    while (txq.size() < 20 && n < 2000) begin
      sample_in = 16'(v);
      sample_valid = (v <= 10);
      fire = sample_valid && sample_ready;
      step();
      if (fire) begin v++; acc++; end
      n++;
    end
    sample_valid = 1'b0;
    checks++;
    if ({acc, 32'(txq.size()), outstanding} !== {32'd10, 32'd20, 8'd10}) begin
      failures++;
      $display("FAIL full_drain got acc=%0d bytes=%0d out=%0d exp 10 20 10", acc, txq.size(), outstanding);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (txq.size() < 2 * i + 2) begin
        failures++;
        $display("FAIL full_word%0d missing", i);
      end else if ({txq[2*i+1], txq[2*i]} !== 16'(i + 1)) begin
        failures++;
        $display("FAIL full_word%0d got=%h exp=%h", i, {txq[2*i+1], txq[2*i]}, 16'(i + 1));
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    n = 0;
    while (TxD_busy && n < 100) begin step(); n++; end
    sample_in = 16'h1111;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n = 0;
    while (outstanding != 8'd1 && n < 100) begin step(); n++; end
    checks++;
    if (outstanding !== 8'd1) begin failures++; $display("FAIL sim_setup got out=%0d exp 1", outstanding); end
    rx_byte(8'h00);
    sample_in = 16'h2222;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n = 0;
    while (!TxD_start && n < 100) begin step(); n++; end
    stuck = 1'b1;
    repeat (15) step();           // model busy expired; FSM parked in TX_MSB
    checks++;
    if ({TxD_start, outstanding} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL sim_wait got start=%b out=%0d exp 0 1", TxD_start, outstanding);
    end
    stuck = 1'b0;
    rx_byte(8'h33);               // MSB start and result registered on one edge
    checks++;
    if ({TxD_start, TxD_data, result_valid, result_out, outstanding}
        !== {1'b1, 8'h22, 1'b1, 16'h3300, 8'd1}) begin
      failures++;
      $display("FAIL sim_both got start=%b data=%h rv=%b res=%h out=%0d exp 1 22 1 3300 1",
               TxD_start, TxD_data, result_valid, result_out, outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_result();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_fifo_full();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
